// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides and a skid register.
// Build option IMM_GEN_AUTO_SEL_EN: decode the format from the opcode and ignore imm_sel.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_NONE = 3'd7
  } imm_fmt_e;

  imm_fmt_e         fmt;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_ext;

  logic             o_valid;
  logic [XLEN-1:0]  o_imm;
  logic [TAG_W-1:0] o_tag;
  logic             k_valid;
  logic [XLEN-1:0]  k_imm;
  logic [TAG_W-1:0] k_tag;

  logic accept;
  logic o_free;

`ifdef IMM_GEN_AUTO_SEL_EN
  logic unused_sel;
  assign unused_sel = ^imm_sel;

  always_comb begin
    fmt = IMM_NONE;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: fmt = IMM_I;
      7'b0100011:                                     fmt = IMM_S;
      7'b1100011:                                     fmt = IMM_B;
      7'b0110111, 7'b0010111:                         fmt = IMM_U;
      7'b1101111:                                     fmt = IMM_J;
      7'b1110011:                                     fmt = instr[14] ? IMM_Z : IMM_I;
      default:                                        fmt = IMM_NONE;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    fmt = IMM_NONE;
    if (imm_sel <= 3'd5) fmt = imm_fmt_e'(imm_sel);
  end
`endif

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 carries the sign for every format (Z has it clear), so one extension fits all.
  assign imm_ext = XLEN'($signed(imm32));

  assign in_ready  = !k_valid;
  assign out_valid = o_valid;
  assign imm_out   = o_imm;
  assign out_tag   = o_tag;

  assign accept = in_valid && !k_valid;
  assign o_free = !o_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_imm   <= '0;
      o_tag   <= '0;
      k_valid <= 1'b0;
      k_imm   <= '0;
      k_tag   <= '0;
    end else if (o_free) begin
      // K only fills while O is held, and in_ready is low while K is full,
      // so a K refill and a new accept never compete for O.
      if (k_valid) begin
        o_valid <= 1'b1;
        o_imm   <= k_imm;
        o_tag   <= k_tag;
        k_valid <= 1'b0;
      end else if (accept) begin
        o_valid <= 1'b1;
        o_imm   <= imm_ext;
        o_tag   <= in_tag;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (accept) begin
      k_valid <= 1'b1;
      k_imm   <= imm_ext;
      k_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus; a queue scoreboard
// holds the words in flight, and its front must match the output every cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [31:0] in_tag;

  logic        in_ready,  out_valid;
  logic [63:0] imm_out;
  logic [31:0] out_tag;
  logic        in_ready32, out_valid32;
  logic [31:0] imm_out32, out_tag32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm_out32), .out_tag(out_tag32)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic [31:0] tag;
  } item_t;

  vec_t  vecs[$];
  item_t pend[$];
  item_t sb[$];
  int    checks = 0;
  int    fails  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, got, want);
    end
  endtask

  task automatic add(input int idx, input logic [31:0] tag);
    item_t it;
    it.v   = vecs[idx];
    it.tag = tag;
    pend.push_back(it);
  endtask

  task automatic out_checks();
    chk("out_valid",   {63'b0, out_valid},   {63'b0, sb.size() > 0});
    chk("in_ready",    {63'b0, in_ready},    {63'b0, sb.size() < 2});
    chk("out_valid32", {63'b0, out_valid32}, {63'b0, sb.size() > 0});
    if (sb.size() > 0) begin
      chk("imm_out",   imm_out,            sb[0].v.exp);
      chk("out_tag",   {32'b0, out_tag},   {32'b0, sb[0].tag});
      chk("imm_out32", {32'b0, imm_out32}, {32'b0, sb[0].v.exp[31:0]});
      chk("out_tag32", {32'b0, out_tag32}, {32'b0, sb[0].tag});
    end
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = stalled
  task automatic step(input int ready_mode, input bit rand_valid);
    bit acc, drn;
    in_valid = (pend.size() > 0) && (!rand_valid || ($urandom_range(0, 3) != 0));
    if (pend.size() > 0) begin
      instr   = pend[0].v.instr;
      imm_sel = pend[0].v.sel;
      in_tag  = pend[0].tag;
    end
    out_ready = (ready_mode == 0) || (ready_mode == 1 && $urandom_range(0, 1) == 1);
    #1;
    out_checks();
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    @(posedge clk);
    if (drn) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(pend[0]);
      void'(pend.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run(input int ready_mode, input bit rand_valid, input int budget);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
      step(ready_mode, rand_valid);
      n++;
    end
    chk("drain_budget", 64'(pend.size() + sb.size()), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs.push_back('{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF}); // 0 addi -1
    vecs.push_back('{32'hFFDFF06F, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC}); // 1 jal -4
    vecs.push_back('{32'hFE000EE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC}); // 2 beq -4
    vecs.push_back('{32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000}); // 3 lui 0x80000
    vecs.push_back('{32'h123450B7, 3'd3, 64'h0000_0000_1234_5000}); // 4 lui 0x12345
    vecs.push_back('{32'h3407D073, 3'd5, 64'h0000_0000_0000_000F}); // 5 csrrwi zimm=15
    vecs.push_back('{32'hFE112C23, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8}); // 6 sw -8
    vecs.push_back('{32'h07B00093, 3'd0, 64'h0000_0000_0000_007B}); // 7 addi 123
`ifdef IMM_GEN_AUTO_SEL_EN
    vecs.push_back('{32'h3407D073, 3'd0, 64'h0000_0000_0000_000F}); // 8 sel ignored
    vecs.push_back('{32'hFFF00093, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF}); // 9 sel ignored
    vecs.push_back('{32'h40000033, 3'd0, 64'h0000_0000_0000_0000}); // 10 R-type opcode
`else
    vecs.push_back('{32'h3407D073, 3'd0, 64'h0000_0000_0000_0340}); // 8 I of csr word
    vecs.push_back('{32'hFFF00093, 3'd7, 64'h0000_0000_0000_0000}); // 9 unused sel
    vecs.push_back('{32'h40000033, 3'd0, 64'h0000_0000_0000_0400}); // 10 I of sub word
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    imm_sel   = '0;
    in_tag    = '0;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_imm_out",   imm_out,            64'd0);
    chk("rst_out_tag",   {32'b0, out_tag},   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // each directed word alone, then all back to back at full throughput
    for (int i = 0; i < vecs.size(); i++) begin
      add(i, 32'h1000 + 32'(i));
      run(0, 0, 10);
    end
    for (int i = 0; i < vecs.size(); i++) add(i, 32'h2000 + 32'(i));
    run(0, 0, 40);

    // 8 tagged words under random backpressure and gaps
    for (int i = 0; i < 8; i++) add(i, 32'hA000 + 32'(i));
    run(1, 1, 200);

    // fill O and K, then reset mid-stream
    add(0, 32'hB000);
    add(3, 32'hB001);
    add(5, 32'hB002);
    step(2, 0);
    step(2, 0);
    step(2, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("midrst_imm_out",   imm_out,            64'd0);
    chk("midrst_out_tag",   {32'b0, out_tag},   64'd0);
    sb.delete();
    pend.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    add(1, 32'hC000);
    run(0, 0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
